// File: rtl/rs_alu.sv
// rs_alu: reservation station in front of the integer ALU.
// Buffers renamed ALU ops, snoops the ALU/LSB result buses for pending
// operands and issues the lowest-index ready entry each cycle.
module rs_alu #(
  parameter int unsigned RS_SIZE_WIDTH  = 3,
  parameter int unsigned ROB_SIZE_WIDTH = 4,
  parameter int unsigned OP_L1_WIDTH    = 4
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      rdy_in,
  input  logic                      need_flush_in,
  input  logic                      inst_valid,
  input  logic [OP_L1_WIDTH-1:0]    inst_op_L1,
  input  logic                      inst_op_L2,
  input  logic [31:0]               inst_vj,
  input  logic [31:0]               inst_vk,
  input  logic                      inst_qj_valid,
  input  logic                      inst_qk_valid,
  input  logic [ROB_SIZE_WIDTH-1:0] inst_qj,
  input  logic [ROB_SIZE_WIDTH-1:0] inst_qk,
  input  logic [ROB_SIZE_WIDTH-1:0] inst_rob_id,
  input  logic                      alu_res_ready,
  input  logic [ROB_SIZE_WIDTH-1:0] alu_res_rob_id,
  input  logic [31:0]               alu_res_value,
  input  logic                      lsb_res_ready,
  input  logic [ROB_SIZE_WIDTH-1:0] lsb_res_rob_id,
  input  logic [31:0]               lsb_res_value,
  output logic                      rs_full,
  output logic                      alu_valid,
  output logic [31:0]               alu_opr1,
  output logic [31:0]               alu_opr2,
  output logic [OP_L1_WIDTH-1:0]    alu_op_L1,
  output logic                      alu_op_L2,
  output logic [ROB_SIZE_WIDTH-1:0] alu_rob_id
);

  localparam int unsigned RS_SIZE = 1 << RS_SIZE_WIDTH;
  localparam int unsigned DATA_W  = 32;

  typedef struct packed {
    logic                      pend;
    logic [ROB_SIZE_WIDTH-1:0] tag;
    logic [DATA_W-1:0]         val;
  } opnd_t;

  typedef struct packed {
    logic [OP_L1_WIDTH-1:0]    op_l1;
    logic                      op_l2;
    opnd_t                     j;
    opnd_t                     k;
    logic [ROB_SIZE_WIDTH-1:0] rob_id;
  } entry_t;

  logic [RS_SIZE-1:0]       busy;
  entry_t                   ent [RS_SIZE];
  logic [RS_SIZE_WIDTH-1:0] free_idx;
  logic [RS_SIZE_WIDTH-1:0] sel_idx;
  logic                     sel_found;
  logic                     do_dispatch;
  entry_t                   new_ent;

  // Capture a pending operand from the result buses; ALU bus has priority.
  function automatic opnd_t snoop(input opnd_t o);
    opnd_t r;
    r = o;
    if (o.pend) begin
      if (alu_res_ready && (alu_res_rob_id == o.tag)) begin
        r.pend = 1'b0;
        r.val  = alu_res_value;
      end else if (lsb_res_ready && (lsb_res_rob_id == o.tag)) begin
        r.pend = 1'b0;
        r.val  = lsb_res_value;
      end
    end
    return r;
  endfunction

  assign rs_full     = &busy;
  assign do_dispatch = inst_valid && !rs_full;

  // Lowest free slot and lowest ready slot, both from registered state.
  always_comb begin
    free_idx  = '0;
    sel_idx   = '0;
    sel_found = 1'b0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy[i]) free_idx = RS_SIZE_WIDTH'(i);
      if (busy[i] && !ent[i].j.pend && !ent[i].k.pend) begin
        sel_found = 1'b1;
        sel_idx   = RS_SIZE_WIDTH'(i);
      end
    end
  end

  // Incoming entry with same-cycle broadcast bypass applied.
  always_comb begin
    new_ent        = '0;
    new_ent.op_l1  = inst_op_L1;
    new_ent.op_l2  = inst_op_L2;
    new_ent.rob_id = inst_rob_id;
    new_ent.j      = snoop({inst_qj_valid, inst_qj, inst_vj});
    new_ent.k      = snoop({inst_qk_valid, inst_qk, inst_vk});
  end

  // Busy bits and issue outputs.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy       <= '0;
      alu_valid  <= 1'b0;
      alu_opr1   <= '0;
      alu_opr2   <= '0;
      alu_op_L1  <= '0;
      alu_op_L2  <= 1'b0;
      alu_rob_id <= '0;
    end else if (rdy_in) begin
      if (need_flush_in) begin
        busy      <= '0;
        alu_valid <= 1'b0;
      end else begin
        alu_valid <= sel_found;
        if (sel_found) begin
          busy[sel_idx] <= 1'b0;
          alu_opr1      <= ent[sel_idx].j.val;
          alu_opr2      <= ent[sel_idx].k.val;
          alu_op_L1     <= ent[sel_idx].op_l1;
          alu_op_L2     <= ent[sel_idx].op_l2;
          alu_rob_id    <= ent[sel_idx].rob_id;
        end
        if (do_dispatch) busy[free_idx] <= 1'b1;
      end
    end
  end

  // Entry payloads: dispatch write into the free slot, wakeup elsewhere.
  always_ff @(posedge clk_in) begin
    if (!rst_in && rdy_in && !need_flush_in) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (do_dispatch && (free_idx == RS_SIZE_WIDTH'(i))) begin
          ent[i] <= new_ent;
        end else if (busy[i]) begin
          ent[i].j <= snoop(ent[i].j);
          ent[i].k <= snoop(ent[i].k);
        end
      end
    end
  end

endmodule

// File: tb/tb_rs_alu.sv
// Scoreboard bench for rs_alu: expected issues are queued at dispatch and
// compared in order whenever the station issues.
module tb_rs_alu;

  typedef struct packed {
    logic [31:0] opr1;
    logic [31:0] opr2;
    logic [3:0]  op1;
    logic        op2;
    logic [3:0]  rob;
  } exp_t;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, need_flush_in;
  logic        inst_valid, inst_op_L2, inst_qj_valid, inst_qk_valid;
  logic [3:0]  inst_op_L1, inst_qj, inst_qk, inst_rob_id;
  logic [31:0] inst_vj, inst_vk;
  logic        alu_res_ready, lsb_res_ready;
  logic [3:0]  alu_res_rob_id, lsb_res_rob_id;
  logic [31:0] alu_res_value, lsb_res_value;
  logic        rs_full, alu_valid, alu_op_L2;
  logic [31:0] alu_opr1, alu_opr2;
  logic [3:0]  alu_op_L1, alu_rob_id;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sb[$];
  logic last_live = 1'b0;

  rs_alu dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .need_flush_in(need_flush_in),
    .inst_valid(inst_valid), .inst_op_L1(inst_op_L1), .inst_op_L2(inst_op_L2),
    .inst_vj(inst_vj), .inst_vk(inst_vk),
    .inst_qj_valid(inst_qj_valid), .inst_qk_valid(inst_qk_valid),
    .inst_qj(inst_qj), .inst_qk(inst_qk), .inst_rob_id(inst_rob_id),
    .alu_res_ready(alu_res_ready), .alu_res_rob_id(alu_res_rob_id), .alu_res_value(alu_res_value),
    .lsb_res_ready(lsb_res_ready), .lsb_res_rob_id(lsb_res_rob_id), .lsb_res_value(lsb_res_value),
    .rs_full(rs_full), .alu_valid(alu_valid), .alu_opr1(alu_opr1), .alu_opr2(alu_opr2),
    .alu_op_L1(alu_op_L1), .alu_op_L2(alu_op_L2), .alu_rob_id(alu_rob_id)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // An issue only counts when the preceding edge was live (not held or reset).
  always @(posedge clk_in) last_live <= rdy_in && !rst_in;

  // Scoreboard compare on the inactive edge.
  always @(negedge clk_in) begin
    if (last_live && alu_valid) begin
      if (sb.size() == 0) begin
        check_eq("spurious_issue_rob", 64'(alu_rob_id), 64'hFFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_eq("issue_opr1",  64'(alu_opr1),   64'(e.opr1));
        check_eq("issue_opr2",  64'(alu_opr2),   64'(e.opr2));
        check_eq("issue_op_L1", 64'(alu_op_L1),  64'(e.op1));
        check_eq("issue_op_L2", 64'(alu_op_L2),  64'(e.op2));
        check_eq("issue_rob",   64'(alu_rob_id), 64'(e.rob));
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic dispatch(input logic [3:0] op1, input logic op2,
                          input logic [31:0] vj, input logic [31:0] vk,
                          input logic qjv, input logic [3:0] qj,
                          input logic qkv, input logic [3:0] qk,
                          input logic [3:0] rob);
    inst_valid    = 1'b1;
    inst_op_L1    = op1;
    inst_op_L2    = op2;
    inst_vj       = vj;
    inst_vk       = vk;
    inst_qj_valid = qjv;
    inst_qj       = qj;
    inst_qk_valid = qkv;
    inst_qk       = qk;
    inst_rob_id   = rob;
  endtask

  task automatic idle_bus();
    inst_valid    = 1'b0;
    alu_res_ready = 1'b0;
    lsb_res_ready = 1'b0;
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; need_flush_in = 1'b0;
    inst_valid = 1'b0; inst_op_L1 = '0; inst_op_L2 = 1'b0;
    inst_vj = '0; inst_vk = '0; inst_qj_valid = 1'b0; inst_qk_valid = 1'b0;
    inst_qj = '0; inst_qk = '0; inst_rob_id = '0;
    alu_res_ready = 1'b0; alu_res_rob_id = '0; alu_res_value = '0;
    lsb_res_ready = 1'b0; lsb_res_rob_id = '0; lsb_res_value = '0;
    tick(); tick();
    rst_in = 1'b0;

    check_eq("rst_alu_valid", 64'(alu_valid), 64'd0);
    check_eq("rst_rs_full",   64'(rs_full),   64'd0);
    check_eq("rst_opr1",      64'(alu_opr1),  64'd0);
    check_eq("rst_opr2",      64'(alu_opr2),  64'd0);
    check_eq("rst_rob",       64'(alu_rob_id), 64'd0);

    // ADD, no dependencies: issues one edge after dispatch.
    dispatch(4'd0, 1'b0, 32'd5, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0, 4'd3);
    sb.push_back('{32'd5, 32'd7, 4'd0, 1'b0, 4'd3});
    tick(); idle_bus();
    check_eq("add_residency", 64'(alu_valid), 64'd0);
    tick();
    check_eq("add_issue", 64'(alu_valid), 64'd1);
    tick();
    check_eq("add_done", 64'(alu_valid), 64'd0);

    // SUB waiting on tag 2; a non-matching broadcast must not wake it.
    dispatch(4'd0, 1'b1, 32'd0, 32'd1, 1'b1, 4'd2, 1'b0, 4'd0, 4'd4);
    sb.push_back('{32'd10, 32'd1, 4'd0, 1'b1, 4'd4});
    tick(); idle_bus();
    alu_res_ready = 1'b1; alu_res_rob_id = 4'd3; alu_res_value = 32'hDEAD;
    tick(); idle_bus();
    check_eq("sub_wait0", 64'(alu_valid), 64'd0);
    tick();
    check_eq("sub_wait1", 64'(alu_valid), 64'd0);
    lsb_res_ready = 1'b1; lsb_res_rob_id = 4'd2; lsb_res_value = 32'd10;
    tick(); idle_bus();
    check_eq("sub_wake_not_yet", 64'(alu_valid), 64'd0);
    tick();
    check_eq("sub_issue", 64'(alu_valid), 64'd1);
    tick();

    // XOR with dispatch-cycle bypass from the ALU bus.
    dispatch(4'd4, 1'b0, 32'd0, 32'd2, 1'b1, 4'd6, 1'b0, 4'd0, 4'd5);
    alu_res_ready = 1'b1; alu_res_rob_id = 4'd6; alu_res_value = 32'hFF;
    sb.push_back('{32'hFF, 32'd2, 4'd4, 1'b0, 4'd5});
    tick(); idle_bus();
    tick();
    check_eq("xor_bypass_issue", 64'(alu_valid), 64'd1);
    tick();

    // Both buses carry the same tag: ALU bus value must win.
    dispatch(4'd1, 1'b0, 32'd3, 32'd0, 1'b0, 4'd0, 1'b1, 4'd7, 4'd6);
    sb.push_back('{32'd3, 32'h111, 4'd1, 1'b0, 4'd6});
    tick(); idle_bus();
    alu_res_ready = 1'b1; alu_res_rob_id = 4'd7; alu_res_value = 32'h111;
    lsb_res_ready = 1'b1; lsb_res_rob_id = 4'd7; lsb_res_value = 32'h222;
    tick(); idle_bus();
    tick();
    check_eq("dual_bus_issue", 64'(alu_valid), 64'd1);
    tick();

    // Fill all eight entries pending on tag 1, then release them.
    for (int i = 0; i < 8; i++) begin
      dispatch(4'd2, 1'b0, 32'd0, 32'(i + 100), 1'b1, 4'd1, 1'b0, 4'd0, 4'(i + 8));
      sb.push_back('{32'd9, 32'(i + 100), 4'd2, 1'b0, 4'(i + 8)});
      tick();
    end
    idle_bus();
    check_eq("fill_full", 64'(rs_full), 64'd1);
    check_eq("fill_no_issue", 64'(alu_valid), 64'd0);
    // Dispatch while full must be ignored.
    dispatch(4'd3, 1'b0, 32'd1, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0, 4'd15);
    tick(); idle_bus();
    alu_res_ready = 1'b1; alu_res_rob_id = 4'd1; alu_res_value = 32'd9;
    tick(); idle_bus();
    check_eq("fill_wake_still_full", 64'(rs_full), 64'd1);
    check_eq("fill_wake_no_issue", 64'(alu_valid), 64'd0);
    tick();
    check_eq("fill_first_issue", 64'(alu_valid), 64'd1);
    check_eq("fill_full_drop", 64'(rs_full), 64'd0);
    for (int i = 1; i < 8; i++) begin
      tick();
      check_eq("fill_drain_valid", 64'(alu_valid), 64'd1);
    end
    tick();
    check_eq("fill_drained", 64'(alu_valid), 64'd0);

    // Three entries woken together, flushed on the edge the first would issue.
    for (int i = 0; i < 3; i++) begin
      dispatch(4'd0, 1'b0, 32'd0, 32'd1, 1'b1, 4'd5, 1'b0, 4'd0, 4'(i));
      tick();
    end
    idle_bus();
    alu_res_ready = 1'b1; alu_res_rob_id = 4'd5; alu_res_value = 32'd1;
    tick(); idle_bus();
    need_flush_in = 1'b1;
    tick();
    need_flush_in = 1'b0;
    check_eq("flush_valid", 64'(alu_valid), 64'd0);
    check_eq("flush_full",  64'(rs_full),   64'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("flush_no_issue", 64'(alu_valid), 64'd0);
    end

    // rdy_in low freezes the station; issue happens on the first live edge.
    dispatch(4'd5, 1'b1, 32'd21, 32'd22, 1'b0, 4'd0, 1'b0, 4'd0, 4'd9);
    sb.push_back('{32'd21, 32'd22, 4'd5, 1'b1, 4'd9});
    tick(); idle_bus();
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("hold_no_issue", 64'(alu_valid), 64'd0);
    end
    rdy_in = 1'b1;
    tick();
    check_eq("hold_release_issue", 64'(alu_valid), 64'd1);
    tick();

    // Bounded drain of anything still expected.
    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    check_eq("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rs_alu.md
# rs_alu

Reservation station for the integer ALU in the out-of-order core. Sits between dispatch and the ALU: it buffers up to 2^RS_SIZE_WIDTH renamed ALU instructions and captures operand values broadcast by the ALU and LSB result buses. Each cycle it issues at most one fully-ready instruction to the ALU. All buffered entries are dropped on a pipeline flush.

## Interface
- RS_SIZE_WIDTH, 3: log2 of entry count (8 entries)
- ROB_SIZE_WIDTH, 4: ROB tag width
- OP_L1_WIDTH, 4: width of ALU level-1 opcode
- clk_in  in  1  clock
- rst_in  in  1  reset; synchronous, active-high
- rdy_in  in  1  global enable; low means hold all state and outputs
- need_flush_in  in  1  misprediction flush
- inst_valid  in  1  dispatch request
- inst_op_L1  in  OP_L1_WIDTH  ALU level-1 op
- inst_op_L2  in  1  ALU level-2 op (sub/sra select)
- inst_vj, inst_vk  in  32  operand values (meaningful when matching q*_valid is 0)
- inst_qj_valid, inst_qk_valid  in  1  operand still pending
- inst_qj, inst_qk  in  ROB_SIZE_WIDTH  producer ROB tag
- inst_rob_id  in  ROB_SIZE_WIDTH  destination ROB tag
- alu_res_ready, alu_res_rob_id (ROB_SIZE_WIDTH), alu_res_value (32)  in  ALU result broadcast
- lsb_res_ready, lsb_res_rob_id (ROB_SIZE_WIDTH), lsb_res_value (32)  in  LSB result broadcast
- rs_full  out  1  no free entry; combinational from registered busy bits only
- alu_valid  out  1  issue strobe to ALU, registered
- alu_opr1, alu_opr2  out  32  operands, registered
- alu_op_L1 (OP_L1_WIDTH), alu_op_L2 (1)  out  opcode, registered
- alu_rob_id  out  ROB_SIZE_WIDTH  destination tag, registered

## Operation
- Per-entry state: busy, op_L1, op_L2, vj, vk, qj_valid, qj, qk_valid, qk, rob_id.
- Dispatch: when inst_valid is high and rs_full is low, write to the lowest-index non-busy entry, determined from the registered busy bits. An entry freed by an issue in the same cycle is not reusable until the next cycle. inst_valid while rs_full is high is a dispatcher error; ignore it.
- Dispatch bypass: if inst_qj_valid is high and a broadcast in the same cycle matches inst_qj, store the broadcast value and clear qj_valid. Same rule for k.
- Wakeup: every busy entry with qj_valid set and qj equal to a valid broadcast tag captures the value and clears qj_valid. Same for k. If both buses carry the same tag, the ALU bus wins.
- Select: the lowest-index busy entry with qj_valid=0 and qk_valid=0, using registered state. Wakeups in the current cycle do not make an entry selectable that cycle.
- Issue: on select, drive alu_* from the entry, set alu_valid=1, and clear busy. With no selection, alu_valid=0 and the other alu_* outputs hold.
- Flush (need_flush_in=1 with rdy_in=1): clear all busy, set alu_valid=0, ignore dispatch and broadcasts that cycle.
- Priority per edge: rst_in > !rdy_in (hold) > flush > normal.
- Reset: all busy=0, alu_valid=0, alu_opr1/alu_opr2=0, alu_op_L1=0, alu_op_L2=0, alu_rob_id=0. Reset mid-operation discards all entries.

## Timing
- Dispatch sampled at edge E: the entry is selectable in the cycle after E, and alu_valid is high after edge E+1 (one cycle minimum residency).
- Broadcast sampled at edge E wakes the entry; it issues at the earliest edge E+1.
- Dispatch-cycle bypass: an operand whose broadcast coincides with dispatch at edge E issues at edge E+1.
- Throughput: one issue per cycle; dispatch and issue can occur in the same cycle on different entries.
- rs_full reflects the registered busy bits of the current cycle. Issuing in cycle N does not deassert rs_full until N+1.
- rdy_in low: no state changes. alu_valid keeps its last value; the ALU also stalls on rdy_in.

## Test plan
- Reset, then dispatch ADD with vj=5, vk=7, rob 3, no dependencies -> next cycle alu_valid=1, opr1=5, opr2=7, op_L1=0, op_L2=0, rob_id=3; the cycle after, alu_valid=0.
- Dispatch SUB with qj=2 pending, vk=1, rob 4; two idle cycles; then lsb_res_ready with tag 2, value 10 -> the cycle after, issue opr1=10, opr2=1, rob_id=4.
- Dispatch XOR with qj=6 in the same cycle as alu_res_ready tag 6 value 0xFF -> bypass captures it; issue next cycle with opr1=0xFF.
- Fill all 8 entries with qj=1 pending -> rs_full=1 and alu_valid stays 0. Broadcast tag 1 value 9 -> issues follow in entry order 0..7 on consecutive cycles, all with opr1=9; rs_full drops the cycle after the first issue.
- Fill 3 ready entries and assert need_flush_in on the same edge as the first would issue -> alu_valid=0, rs_full=0, and no issue on any later cycle.
- Hold rdy_in low for 3 cycles with a ready entry present -> no issue. Raise rdy_in -> issue on the next edge.
